// File: rtl/line_capture_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : line_capture_ctrl
// Purpose  : Captures one sensor line (PIX_NUM samples, after skipping the
//            first PIX_SKIP pixels) into the 512x8 transmit buffer. It then
//            hands the buffer to the UART transmit controller with a tx_start
//            pulse and holds the buffer until tx_complete arrives.
//            Supports single-shot (arm) and continuous (cont_mode) capture.
// Revision : 1.0 - initial release
// ============================================================================
module line_capture_ctrl #(
  parameter int ADC_W      = 12,  // sensor ADC sample width
  parameter int DATA_SHIFT = 4,   // LSB of the 8-bit slice; DATA_SHIFT+7 <= ADC_W-1
  parameter int PIX_SKIP   = 16,  // pixels discarded after each line start (0..511)
  parameter int PIX_NUM    = 512  // pixels stored per frame, equals buffer depth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             cont_mode,
  input  logic             line_sync,
  input  logic             pix_valid,
  input  logic [ADC_W-1:0] pix_data,
  output logic             wr_en,
  output logic [8:0]       wr_adress,
  output logic [7:0]       wr_data,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic             tx_complete,
  output logic             busy,
  output logic             overrun_err,
  output logic [15:0]      frame_cnt
);

  localparam int IDX_W = 10;

  // The skip threshold and the last buffer address, pre-sized for comparison
  localparam logic [IDX_W-1:0] SKIP_THR  = IDX_W'(PIX_SKIP);
  localparam logic [8:0]       LAST_ADDR = 9'(PIX_NUM - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_SYNC = 3'd1;
  localparam logic [2:0] S_SKIP      = 3'd2;
  localparam logic [2:0] S_CAPTURE   = 3'd3;
  localparam logic [2:0] S_START_TX  = 3'd4;
  localparam logic [2:0] S_WAIT_TX   = 3'd5;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic             sync_d;
  logic [IDX_W-1:0] pix_idx;      // pixel index in the line, saturates at PIX_SKIP
  logic [IDX_W-1:0] pix_idx_nxt;
  logic [8:0]       wr_ptr;       // address of the next kept pixel
  logic [8:0]       wr_ptr_nxt;
  logic             overrun_nxt;
  logic [15:0]      frame_cnt_nxt;

  // Output next-values
  logic             wr_en_nxt;
  logic [8:0]       wr_adress_nxt;
  logic [7:0]       wr_data_nxt;
  logic             tx_start_nxt;
  logic             busy_nxt;

  // --------------------------------------------------------------------------
  // Line-level decode shared by the next-state and output logic
  // --------------------------------------------------------------------------
  logic             sync_rise;
  logic             in_line;      // states where line_sync / pix_valid matter
  logic             line_restart; // a new line begins this cycle
  logic             active;       // pixels are being counted this cycle
  logic [IDX_W-1:0] cur_idx;      // index of a pixel arriving this cycle
  logic [8:0]       cur_ptr;      // address a kept pixel would use this cycle
  logic             keep;         // this cycle's pixel is written to the buffer
  logic             last;         // this cycle's pixel fills the frame
  logic             count_pix;

  // Only the sliced bits reach the buffer; the rest are intentionally dropped
  logic             unused_pix_bits;
  assign unused_pix_bits = ^pix_data;

  assign sync_rise    = line_sync & ~sync_d;
  assign in_line      = (state == S_WAIT_SYNC) || (state == S_SKIP) || (state == S_CAPTURE);
  assign line_restart = in_line & sync_rise;
  // A pixel coinciding with the line start is pixel 0 of the new line
  assign active       = (state == S_SKIP) || (state == S_CAPTURE) || line_restart;
  assign cur_idx      = line_restart ? '0 : pix_idx;
  assign cur_ptr      = (line_restart || (state == S_WAIT_SYNC)) ? '0 : wr_ptr;
  assign keep         = active & pix_valid & (cur_idx >= SKIP_THR);
  assign last         = keep & (cur_ptr == LAST_ADDR);
  assign count_pix    = active & pix_valid & (cur_idx < SKIP_THR);

  // State register together with the line counters, sync history and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sync_d      <= 1'b0;
      pix_idx     <= '0;
      wr_ptr      <= '0;
      overrun_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      sync_d      <= line_sync;
      pix_idx     <= pix_idx_nxt;
      wr_ptr      <= wr_ptr_nxt;
      overrun_err <= overrun_nxt;
      frame_cnt   <= frame_cnt_nxt;
    end
  end

  // Next-state logic: capture sequencing, overrun handling and handshake
  always_comb begin
    state_nxt     = state;
    pix_idx_nxt   = cur_idx;
    wr_ptr_nxt    = cur_ptr;
    overrun_nxt   = overrun_err;
    frame_cnt_nxt = frame_cnt;

    if (count_pix) begin
      pix_idx_nxt = cur_idx + 1'b1;
    end
    // Wraps to 0 only after the last address, which also ends the frame
    if (keep) begin
      wr_ptr_nxt = cur_ptr + 1'b1;
    end

    case (state)
      S_IDLE: begin
        if (arm) begin
          state_nxt   = S_WAIT_SYNC;
          overrun_nxt = 1'b0;
        end
      end
      S_WAIT_SYNC, S_SKIP, S_CAPTURE: begin
        // A new line before the frame filled restarts it and flags overrun
        if (line_restart && (state != S_WAIT_SYNC)) begin
          overrun_nxt = 1'b1;
        end
        if (last) begin
          state_nxt = S_START_TX;
        end else if (keep) begin
          state_nxt = S_CAPTURE;
        end else if (line_restart) begin
          state_nxt = S_SKIP;
        end
      end
      S_START_TX: begin
        if (!tx_busy) begin
          state_nxt     = S_WAIT_TX;
          frame_cnt_nxt = frame_cnt + 1'b1;
        end
      end
      S_WAIT_TX: begin
        // cont_mode is only looked at here, so a frame in flight always finishes
        if (tx_complete) begin
          state_nxt = cont_mode ? S_WAIT_SYNC : S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered buffer/handshake outputs
  always_comb begin
    wr_en_nxt     = keep;
    wr_adress_nxt = wr_adress;
    wr_data_nxt   = wr_data;
    tx_start_nxt  = (state == S_START_TX) && !tx_busy;
    busy_nxt      = (state_nxt != S_IDLE);
    if (keep) begin
      wr_adress_nxt = cur_ptr;
      wr_data_nxt   = pix_data[DATA_SHIFT +: 8];
    end
  end

  // Output registers: single-cycle latency from pixel strobe to buffer write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_adress <= '0;
      wr_data   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_en     <= wr_en_nxt;
      wr_adress <= wr_adress_nxt;
      wr_data   <= wr_data_nxt;
      tx_start  <= tx_start_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_line_capture_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_line_capture_ctrl
// Purpose  : Self-checking bench for line_capture_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_capture_ctrl;

  localparam int SKIP = 16;
  localparam int NPIX = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        cont_mode = 1'b0;
  logic        line_sync = 1'b0;
  logic        pix_valid = 1'b0;
  logic [11:0] pix_data = '0;
  logic        tx_busy = 1'b0;
  logic        tx_complete = 1'b0;

  logic        wr_en, tx_start, busy, overrun_err;
  logic [8:0]  wr_adress;
  logic [7:0]  wr_data;
  logic [15:0] frame_cnt;

  logic        z_wr_en, z_tx_start, z_busy, z_overrun_err;
  logic [8:0]  z_wr_adress;
  logic [7:0]  z_wr_data;
  logic [15:0] z_frame_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t wq[$];
  wr_t exp_q[$];
  int  ts_q[$];

  typedef struct {
    logic        arm;
    logic        ls;
    logic        pv;
    logic [11:0] pd;
    logic        we;
    logic [8:0]  a;
    logic [7:0]  d;
    logic        bz;
    logic        ov;
  } vec_t;

  vec_t tbl[10];

  line_capture_ctrl #(.ADC_W(12), .DATA_SHIFT(4), .PIX_SKIP(SKIP), .PIX_NUM(NPIX)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .cont_mode(cont_mode), .line_sync(line_sync),
    .pix_valid(pix_valid), .pix_data(pix_data), .wr_en(wr_en), .wr_adress(wr_adress),
    .wr_data(wr_data), .tx_start(tx_start), .tx_busy(tx_busy), .tx_complete(tx_complete),
    .busy(busy), .overrun_err(overrun_err), .frame_cnt(frame_cnt)
  );

  // Second instance with no skipped pixels for the coincidence/latency table
  line_capture_ctrl #(.ADC_W(12), .DATA_SHIFT(4), .PIX_SKIP(0), .PIX_NUM(NPIX)) dut0 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .cont_mode(cont_mode), .line_sync(line_sync),
    .pix_valid(pix_valid), .pix_data(pix_data), .wr_en(z_wr_en), .wr_adress(z_wr_adress),
    .wr_data(z_wr_data), .tx_start(z_tx_start), .tx_busy(tx_busy), .tx_complete(tx_complete),
    .busy(z_busy), .overrun_err(z_overrun_err), .frame_cnt(z_frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every buffer write and every tx_start cycle of the main instance
  always @(negedge clk) begin
    if (wr_en) wq.push_back('{wr_adress, wr_data, cyc});
    if (tx_start) ts_q.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, ex);
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_wr_en"},     32'(wr_en),       32'd0);
    chk({pfx, "_wr_adress"}, 32'(wr_adress),   32'd0);
    chk({pfx, "_wr_data"},   32'(wr_data),     32'd0);
    chk({pfx, "_tx_start"},  32'(tx_start),    32'd0);
    chk({pfx, "_busy"},      32'(busy),        32'd0);
    chk({pfx, "_overrun"},   32'(overrun_err), 32'd0);
    chk({pfx, "_frame_cnt"}, 32'(frame_cnt),   32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; cont_mode = 1'b0; line_sync = 1'b0;
    pix_valid = 1'b0; pix_data = '0; tx_busy = 1'b0; tx_complete = 1'b0;
    step();
    step();
    check_zero("reset");
    rst_n = 1'b1;
    step();
    wq.delete();
    exp_q.delete();
    ts_q.delete();
  endtask

  // Drive one line (line_sync high throughout, pixel 0 coincident with the
  // rising edge). When capture is set, the reference model appends the
  // expected writes: kept pixel i (i >= SKIP) goes to address i-SKIP, one
  // cycle after its strobe, until the frame holds NPIX samples.
  task automatic send_line(input int npix, input int gap_pct, input bit ramp,
                           input bit capture, input bit arm_noise);
    int i = 0;
    int k = 0;
    logic [11:0] d;
    step();
    line_sync = 1'b1;
    while (i < npix) begin
      if (arm_noise) arm = ($urandom_range(7) == 0);
      if (i == 0 || int'($urandom_range(99)) >= gap_pct) begin
        d = ramp ? 12'(i << 4) : 12'($urandom_range(4095));
        pix_valid = 1'b1;
        pix_data  = d;
        if (capture && i >= SKIP && k < NPIX) begin
          exp_q.push_back('{9'(k), d[11:4], cyc + 1});
          k++;
        end
        i++;
      end else begin
        pix_valid = 1'b0;
        pix_data  = 12'($urandom_range(4095));
      end
      step();
    end
    pix_valid = 1'b0;
    line_sync = 1'b0;
    arm = 1'b0;
  endtask

  // Random pixels and line_sync activity that must not reach the buffer
  task automatic noise(input int n);
    for (int j = 0; j < n; j++) begin
      pix_valid = 1'($urandom_range(1));
      pix_data  = 12'($urandom_range(4095));
      if (j % 37 == 0) line_sync = ~line_sync;
      step();
    end
    pix_valid = 1'b0;
    line_sync = 1'b0;
  endtask

  task automatic wait_ts(input int n, input int limit, input string nm);
    int t = 0;
    while (ts_q.size() < n && t < limit) begin
      step();
      t++;
    end
    chk(nm, 32'(ts_q.size()), 32'(n));
  endtask

  task automatic pulse_complete();
    step();
    tx_complete = 1'b1;
    step();
    tx_complete = 1'b0;
    step();
  endtask

  task automatic check_writes(input string nm);
    int bi = -1;
    int n;
    chk({nm, "_count"}, 32'(wq.size()), 32'(exp_q.size()));
    n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (wq[i].a !== exp_q[i].a || wq[i].d !== exp_q[i].d || wq[i].c != exp_q[i].c) begin
        bi = i;
        break;
      end
    end
    total++;
    if (bi >= 0) begin
      bad++;
      $display("FAIL %s_content: write %0d got a=%0d d=0x%0h cyc=%0d expected a=%0d d=0x%0h cyc=%0d",
               nm, bi, wq[bi].a, wq[bi].d, wq[bi].c, exp_q[bi].a, exp_q[bi].d, exp_q[bi].c);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t_fall;

    do_reset();

    // ---- Table: PIX_SKIP=0 instance, coincident sync/pixel, latency, overrun
    //           arm    ls     pv     data      we     addr   data   busy   ovr
    tbl[0] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 9'd0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 9'd0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 12'h5A3, 1'b1, 9'd0, 8'h5A, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 9'd0, 8'h5A, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 12'h123, 1'b1, 9'd1, 8'h12, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 12'hFFF, 1'b1, 9'd2, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 9'd2, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 12'h340, 1'b1, 9'd0, 8'h34, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 12'h001, 1'b1, 9'd1, 8'h00, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 9'd1, 8'h00, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      arm = tbl[i].arm; line_sync = tbl[i].ls; pix_valid = tbl[i].pv; pix_data = tbl[i].pd;
      step();
      chk($sformatf("vec%0d_wr_en", i),   32'(z_wr_en),       32'(tbl[i].we));
      chk($sformatf("vec%0d_addr", i),    32'(z_wr_adress),   32'(tbl[i].a));
      chk($sformatf("vec%0d_data", i),    32'(z_wr_data),     32'(tbl[i].d));
      chk($sformatf("vec%0d_busy", i),    32'(z_busy),        32'(tbl[i].bz));
      chk($sformatf("vec%0d_overrun", i), 32'(z_overrun_err), 32'(tbl[i].ov));
    end

    // ---- Single shot with ramp data: address k carries (k+16)&0xFF
    do_reset();
    arm = 1'b1; step(); arm = 1'b0;
    send_line(600, 0, 1'b1, 1'b1, 1'b0);
    wait_ts(1, 100, "single_tx_start");
    check_writes("single");
    chk("single_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("single_busy_before_done", 32'(busy), 32'd1);
    chk("single_overrun", 32'(overrun_err), 32'd0);
    pulse_complete();
    chk("single_busy_after_done", 32'(busy), 32'd0);
    chk("single_tx_start_count", 32'(ts_q.size()), 32'd1);

    // ---- Overrun: new line after 300 writes, then a full frame
    do_reset();
    arm = 1'b1; step(); arm = 1'b0;
    send_line(SKIP + 300, 30, 1'b0, 1'b1, 1'b0);
    chk("ovr_before", 32'(overrun_err), 32'd0);
    send_line(600, 30, 1'b0, 1'b1, 1'b0);
    wait_ts(1, 100, "ovr_tx_start");
    chk("ovr_flag", 32'(overrun_err), 32'd1);
    check_writes("ovr");
    pulse_complete();
    chk("ovr_sticky_idle", 32'(overrun_err), 32'd1);
    arm = 1'b1; step(); arm = 1'b0;
    chk("ovr_cleared_by_arm", 32'(overrun_err), 32'd0);

    // ---- Busy gating: tx_start only after tx_busy falls, buffer protected
    do_reset();
    tx_busy = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    send_line(600, 20, 1'b0, 1'b1, 1'b0);
    noise(1000);
    chk("busy_hold_no_start", 32'(ts_q.size()), 32'd0);
    tx_busy = 1'b0;
    t_fall = cyc;
    step();
    step();
    chk("busy_start_count", 32'(ts_q.size()), 32'd1);
    chk("busy_start_cycle", 32'((ts_q.size() > 0) ? ts_q[0] : -1), 32'(t_fall + 1));
    noise(60);
    chk("busy_start_width", 32'(ts_q.size()), 32'd1);
    check_writes("busy");
    chk("busy_frame_cnt", 32'(frame_cnt), 32'd1);

    // ---- Continuous mode: three frames, stray arm pulses during capture
    do_reset();
    cont_mode = 1'b1;
    arm = 1'b1; step(); arm = 1'b0;
    for (int f = 0; f < 3; f++) begin
      send_line(560, 25, 1'b0, 1'b1, 1'b1);
      wait_ts(f + 1, 200, $sformatf("cont_tx_start%0d", f));
      repeat (3) step();
      if (f == 2) cont_mode = 1'b0;
      pulse_complete();
    end
    chk("cont_start_count", 32'(ts_q.size()), 32'd3);
    chk("cont_frame_cnt", 32'(frame_cnt), 32'd3);
    chk("cont_busy_end", 32'(busy), 32'd0);
    check_writes("cont");

    // ---- Asynchronous reset in the middle of a frame (after write 200)
    do_reset();
    arm = 1'b1; step(); arm = 1'b0;
    send_line(SKIP + 200, 0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check_writes("pre_reset");
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    wq.delete();
    ts_q.delete();
    step();
    rst_n = 1'b1;
    send_line(600, 10, 1'b0, 1'b0, 1'b0);
    repeat (20) step();
    chk("post_rst_no_write", 32'(wq.size()), 32'd0);
    chk("post_rst_no_start", 32'(ts_q.size()), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_capture_ctrl.md
Name: line_capture_ctrl

Overview:
- Captures one sensor line of 512 pixel samples into the 512x8 transmit buffer RAM, via its write port.
- Then hands the buffer to the downstream UART transmit controller by pulsing tx_start.
- Waits for that controller's tx_complete before the buffer may be overwritten.
- Supports single-shot capture (on arm) and continuous capture (cont_mode).

Parameters:
- ADC_W, 12, width of the sensor ADC sample.
- DATA_SHIFT, 4, LSB index of the 8-bit slice taken from pix_data; requires DATA_SHIFT+7 <= ADC_W-1.
- PIX_SKIP, 16, number of pixels discarded after each line_sync rising edge (0..511).
- PIX_NUM, 512, pixels stored per frame; must equal buffer depth.

Ports:
- clk  in  1  system clock (10 MHz), sole clock domain.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  single-cycle request to capture the next line; honoured only in IDLE.
- cont_mode  in  1  1 = re-arm automatically after each completed transmission.
- line_sync  in  1  sensor line start, clk-synchronous level; rising edge marks a new line.
- pix_valid  in  1  one-cycle strobe, pix_data valid.
- pix_data  in  ADC_W  sensor sample.
- wr_en  out  1  buffer write enable.
- wr_adress  out  9  buffer write address.
- wr_data  out  8  buffer write data = pix_data[DATA_SHIFT+7:DATA_SHIFT].
- tx_start  out  1  one-cycle pulse to the transmit controller.
- tx_busy  in  1  transmit controller busy (level).
- tx_complete  in  1  transmit controller done (one-cycle pulse).
- busy  out  1  high whenever state != IDLE.
- overrun_err  out  1  sticky; line_sync rose before the frame filled.
- frame_cnt  out  16  frames handed to transmitter; wraps 0xFFFF->0.

Behaviour:
- Reset (async, rst_n=0): state IDLE; wr_en, tx_start, overrun_err = 0; wr_adress, wr_data, frame_cnt, pixel counter = 0; sync_d = 0. All outputs are registered.
- Edge detect: sync_rise = line_sync & ~sync_d, with sync_d the line_sync value registered on clk.
- IDLE:
  - arm=1 -> WAIT_SYNC; overrun_err cleared on the same edge.
  - arm in any other state is ignored.
- WAIT_SYNC: on sync_rise -> SKIP; pixel counter pix_idx = 0.
- SKIP / CAPTURE pixel indexing:
  - Each pix_valid increments pix_idx.
  - pix_valid in the same cycle as sync_rise is pixel 0 of the new line.
  - Pixels with pix_idx < PIX_SKIP are discarded.
  - The first kept pixel moves the FSM to CAPTURE and is written to address 0.
- Write timing (CAPTURE): pix_valid sampled at cycle N -> wr_en=1, wr_adress, wr_data valid at cycle N+1 (single-cycle latency). wr_en is low otherwise.
- Frame end:
  - The write to address PIX_NUM-1 completes the frame -> START_TX.
  - wr_adress holds 511; it never wraps inside a frame.
- Overrun: sync_rise in SKIP or CAPTURE before the frame completes ->
  - overrun_err=1;
  - address restarts at 0, pix_idx=0, FSM -> SKIP;
  - pix_valid in that cycle counts as pixel 0.
- START_TX:
  - While tx_busy=1, wait.
  - First cycle with tx_busy=0: tx_start=1 for exactly one cycle, frame_cnt+1, -> WAIT_TX.
- WAIT_TX:
  - wr_en is forced 0 (buffer protected); pix_valid and line_sync are ignored.
  - On tx_complete: cont_mode=1 -> WAIT_SYNC; else -> IDLE.
  - tx_complete in any other state is ignored.
- cont_mode is sampled only on the WAIT_TX exit; clearing it mid-frame lets the current frame finish.
- Reset mid-frame: immediate return to IDLE; partial buffer contents undefined; no tx_start issued.

Test Plan:
- Single shot, PIX_SKIP=16: arm, line_sync rise, 600 pix_valid with pix_data=i<<4 -> exactly 512 wr_en pulses; address k carries data (k+16)&0xFF; one tx_start; frame_cnt=1; tx_complete -> IDLE, busy=0.
- Latency/coincidence: pix_valid and sync_rise in the same cycle with PIX_SKIP=0 -> write to address 0 with that sample exactly one cycle later.
- Overrun: second line_sync rise after 300 writes -> overrun_err=1; next write at address 0; full 512 writes then tx_start; overrun_err stays 1 until the next arm.
- Busy gating: frame completes while tx_busy=1 for 1000 cycles -> tx_start asserted on the first cycle after tx_busy falls, width 1; no wr_en during WAIT_TX despite continuing pixels.
- Continuous mode: cont_mode=1 over 3 lines -> 3 tx_start pulses; frame_cnt=3; arm pulses during capture have no effect.
- Async reset at write 200 -> all outputs 0 within the reset assertion; after release, no tx_start without a new arm.
